pc_fetch_unit: RTL and testbench

Sequential instruction-fetch front end: owns the program counter, issues one instruction-memory request at a time over a req/ready + valid handshake, holds the returned instruction for decode under back-pressure, and accepts the jump/jr target computed by the jump-address logic as the next PC. It sits between instruction memory and decode, and supplies `pc` and `pcStepAdder` (PC+4) to the datapath.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/pc_incrementer.sv | 17 +
 rtl/pc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t : fetch sequencer states (RESET, REQ, WAIT, HOLD)
//   INST_STEP     : byte distance between sequential instructions
//   STALL_CNT_W   : width of the optional decode-stall counter
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INST_STEP   = 32'd4;
  localparam int          STALL_CNT_W = 16;

endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer
// Sequential-address adder for the fetch unit. Produces pc + INST_STEP,
// wrapping modulo 2^32 so the top of the address space rolls over to 0.
// Ports:
//   pc      in  32  current program counter
//   pc_next out 32  pc + INST_STEP (mod 2^32)
module pc_incrementer
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_next
);

  // Plain 32-bit add; carry out is dropped on purpose to get the wrap.
  assign pc_next = pc + INST_STEP;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch front end. Owns the program counter, issues one
// instruction-memory request at a time, holds the returned word for decode
// while decode stalls, and then steps the PC sequentially or to a jump target.
// Ports:
//   clk          in  1   rising-edge clock
//   rst          in  1   synchronous active-high reset
//   jump         in  1   held instruction is J/JAL/JR (only used on consume)
//   jumpAddr     in  32  jump target; low two bits are cleared
//   stall        in  1   decode cannot take the held instruction
//   imemReq      out 1   fetch request (registered)
//   imemAddr     out 32  request address, equal to pc
//   imemReady    in  1   memory accepts the request
//   imemValid    in  1   read data valid (only honoured in WAIT)
//   imemData     in  32  instruction word
//   instValid    out 1   inst holds a valid instruction
//   inst         out 32  held instruction
//   pc           out 32  address of current/held instruction
//   pcStepAdder  out 32  pc + 4
//   stallCnt     out 16  saturating count of stalled cycles (STALL_CNT_EN only)
// Optional feature: define STALL_CNT_EN to add the stallCnt output.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [31:0] jumpAddr,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic        instValid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pcStepAdder
`ifdef STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stallCnt
`endif
);

  fetch_state_t state;
  fetch_state_t next_state;
  logic [31:0]  next_pc;
  logic [31:0]  next_inst;
  logic         next_valid;
  logic         next_req;
  logic         consume;

  pc_incrementer u_pc_incrementer (
    .pc      (pc),
    .pc_next (pcStepAdder)
  );

  assign imemAddr = pc;
  assign consume  = instValid && !stall;

  // Next-state and next-register logic. imemReq is registered from the
  // next state so it is high exactly for the cycles spent in REQ.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_inst  = inst;
    next_valid = instValid;
    case (state)
      RESET: next_state = REQ;
      REQ: begin
        if (imemReady) next_state = WAIT;
      end
      WAIT: begin
        if (imemValid) begin
          next_state = HOLD;
          next_inst  = imemData;
          next_valid = 1'b1;
        end
      end
      HOLD: begin
        if (consume) begin
          next_pc    = jump ? (jumpAddr & ~32'h3) : pcStepAdder;
          next_valid = 1'b0;
          next_state = REQ;
        end
      end
      default: next_state = RESET;
    endcase
    next_req = (next_state == REQ);
  end

  // State and output registers; reset wins over every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET;
      pc        <= RESET_PC;
      inst      <= 32'h0;
      instValid <= 1'b0;
      imemReq   <= 1'b0;
    end else begin
      state     <= next_state;
      pc        <= next_pc;
      inst      <= next_inst;
      instValid <= next_valid;
      imemReq   <= next_req;
    end
  end

`ifdef STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Counts cycles where a valid instruction is blocked by decode, sticking
  // at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (instValid && stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stallCnt = stall_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Directed, table-driven bench for pc_fetch_unit (RESET_PC = 0), plus a
// hand-written sequence covering stall counting and reset during HOLD.
module tb_pc_fetch_unit;

  typedef struct {
    string       name;
    logic        rst;
    logic        ready;
    logic        valid;
    logic [31:0] data;
    logic        stall;
    logic        jump;
    logic [31:0] jumpAddr;
    logic        expReq;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expPc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        jump;
  logic [31:0] jumpAddr;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemValid;
  logic [31:0] imemData;
  logic        instValid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pcStepAdder;
`ifdef STALL_CNT_EN
  logic [15:0] stallCnt;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .jump        (jump),
    .jumpAddr    (jumpAddr),
    .stall       (stall),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemReady   (imemReady),
    .imemValid   (imemValid),
    .imemData    (imemData),
    .instValid   (instValid),
    .inst        (inst),
    .pc          (pc),
    .pcStepAdder (pcStepAdder)
`ifdef STALL_CNT_EN
    ,
    .stallCnt    (stallCnt)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic applyStimulus(input logic r, input logic rdy, input logic vld,
                               input logic [31:0] data, input logic stl,
                               input logic jmp, input logic [31:0] ja);
    rst       = r;
    imemReady = rdy;
    imemValid = vld;
    imemData  = data;
    stall     = stl;
    jump      = jmp;
    jumpAddr  = ja;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string nm, input logic r, input logic rdy,
                        input logic vld, input logic [31:0] data,
                        input logic stl, input logic jmp, input logic [31:0] ja,
                        input logic eReq, input logic eValid,
                        input logic [31:0] eInst, input logic [31:0] ePc);
    vec_t v;
    v.name = nm; v.rst = r; v.ready = rdy; v.valid = vld; v.data = data;
    v.stall = stl; v.jump = jmp; v.jumpAddr = ja; v.expReq = eReq;
    v.expValid = eValid; v.expInst = eInst; v.expPc = ePc;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] plusFour(input logic [31:0] a);
    logic [31:0] r;
    r = a + 32'd4;
    return r;
  endfunction

  initial begin
    int budget;
    rst = 1'b1; imemReady = 1'b0; imemValid = 1'b0; imemData = 32'h0;
    stall = 1'b0; jump = 1'b0; jumpAddr = 32'h0;

    //     name            rst rdy vld data          stl jmp jumpAddr      req val inst          pc
    addVec("reset0",        1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0);
    addVec("reset1",        1, 1, 1, 32'h1111_1111, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0);
    addVec("release",       0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         32'h0);
    addVec("accept0",       0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0);
    addVec("data0",         0, 0, 1, 32'h2002_0005, 0, 0, 32'h0,         0, 1, 32'h2002_0005, 32'h0);
    addVec("consume0",      0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h2002_0005, 32'h4);
    addVec("notReady",      0, 0, 1, 32'h5555_5555, 0, 0, 32'h0,         1, 0, 32'h2002_0005, 32'h4);
    addVec("accept1",       0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h2002_0005, 32'h4);
    addVec("waitIdle",      0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h2002_0005, 32'h4);
    addVec("data1",         0, 0, 1, 32'h8C01_0000, 0, 0, 32'h0,         0, 1, 32'h8C01_0000, 32'h4);
    for (int i = 0; i < 5; i++)
      addVec("stallHold",   0, 1, 1, 32'hBAD0_BAD0, 1, 1, 32'h1234_5678, 0, 1, 32'h8C01_0000, 32'h4);
    addVec("stallRelease",  0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h8C01_0000, 32'h8);
    addVec("accept2",       0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h8C01_0000, 32'h8);
    addVec("data2",         0, 0, 1, 32'h0810_0004, 0, 0, 32'h0,         0, 1, 32'h0810_0004, 32'h8);
    addVec("jumpTaken",     0, 0, 0, 32'h0,         0, 1, 32'h0040_0013, 1, 0, 32'h0810_0004, 32'h0040_0010);
    addVec("accept3",       0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0810_0004, 32'h0040_0010);
    addVec("data3",         0, 0, 1, 32'h0000_0020, 0, 0, 32'h0,         0, 1, 32'h0000_0020, 32'h0040_0010);
    addVec("seqAfterJump",  0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0000_0020, 32'h0040_0014);
    addVec("accept4",       0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0000_0020, 32'h0040_0014);
    addVec("data4",         0, 0, 1, 32'h03E0_0008, 0, 0, 32'h0,         0, 1, 32'h03E0_0008, 32'h0040_0014);
    addVec("jumpTop",       0, 0, 0, 32'h0,         0, 1, 32'hFFFF_FFFF, 1, 0, 32'h03E0_0008, 32'hFFFF_FFFC);
    addVec("accept5",       0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h03E0_0008, 32'hFFFF_FFFC);
    addVec("data5",         0, 0, 1, 32'h0000_0000, 0, 0, 32'h0,         0, 1, 32'h0000_0000, 32'hFFFF_FFFC);
    addVec("pcWrap",        0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0000_0000, 32'h0);
    addVec("accept6",       0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0000_0000, 32'h0);
    addVec("resetInWait",   1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0);
    addVec("staleData",     0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 0, 32'h0,         32'h0);
    addVec("staleInReq",    0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 0, 32'h0,         32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].ready, vecs[i].valid, vecs[i].data,
                    vecs[i].stall, vecs[i].jump, vecs[i].jumpAddr);
      checkOutput({vecs[i].name, ".imemReq"},   {31'h0, imemReq},   {31'h0, vecs[i].expReq});
      checkOutput({vecs[i].name, ".instValid"}, {31'h0, instValid}, {31'h0, vecs[i].expValid});
      checkOutput({vecs[i].name, ".inst"},      inst,               vecs[i].expInst);
      checkOutput({vecs[i].name, ".pc"},        pc,                 vecs[i].expPc);
      checkOutput({vecs[i].name, ".imemAddr"},  imemAddr,           vecs[i].expPc);
      checkOutput({vecs[i].name, ".pcStep"},    pcStepAdder,        plusFour(vecs[i].expPc));
`ifdef STALL_CNT_EN
      if (vecs[i].name == "stallRelease")
        checkOutput("stallCnt.afterFive", {16'h0, stallCnt}, 32'd5);
`endif
    end

    // Hand-written sequence: fetch, stall twice, then reset while in HOLD.
    budget = 10;
    while (!imemReq && budget > 0) begin
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
      budget--;
    end
    checkOutput("seq.reqSeen", {31'h0, imemReq}, 32'd1);
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 32'hCAFE_0001, 0, 0, 32'h0);
    checkOutput("seq.holdValid", {31'h0, instValid}, 32'd1);
    checkOutput("seq.holdInst", inst, 32'hCAFE_0001);
    applyStimulus(0, 0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 1, 1, 32'h0000_1000);
    checkOutput("seq.stallPc", pc, 32'h0);
    checkOutput("seq.stallNoReq", {31'h0, imemReq}, 32'd0);
`ifdef STALL_CNT_EN
    checkOutput("seq.stallCnt", {16'h0, stallCnt}, 32'd2);
`endif
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("seq.rstValid", {31'h0, instValid}, 32'd0);
    checkOutput("seq.rstInst", inst, 32'h0);
    checkOutput("seq.rstReq", {31'h0, imemReq}, 32'd0);
`ifdef STALL_CNT_EN
    checkOutput("seq.rstStallCnt", {16'h0, stallCnt}, 32'd0);
`endif
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("seq.reqAfterRst", {31'h0, imemReq}, 32'd1);
    checkOutput("seq.addrAfterRst", imemAddr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
